// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// the counter sizing helper.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_NOP6  = 3'd6,
      MD_NOP7  = 3'd7
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_t;

   // Counter must hold the largest reload value (L-1); sized from max(L)+1.
   function automatic int md_cnt_width(input int mul_cycles, input int div_cycles);
      int longest;
      longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: maps latched op/A/B to the HI/LO
// values written when the operation completes.
module md_calc
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_t            op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  hi_next,
   output logic [WIDTH-1:0]  lo_next
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic                       is_signed;
   logic signed [2*WIDTH-1:0]  a_ext;
   logic signed [2*WIDTH-1:0]  b_ext;
   logic signed [2*WIDTH-1:0]  prod;
   logic                       a_neg;
   logic                       b_neg;
   logic [WIDTH-1:0]           dvd;
   logic [WIDTH-1:0]           dvs;
   logic [WIDTH-1:0]           dvs_safe;
   logic [WIDTH-1:0]           quo;
   logic [WIDTH-1:0]           rem;
   logic [WIDTH-1:0]           quo_fix;
   logic [WIDTH-1:0]           rem_fix;
   logic                       div_zero;
   logic                       div_ovf;

   always_comb begin
      is_signed = (op == MD_MULT) || (op == MD_DIV);

      // A 2W x 2W product of the extended operands yields the exact 2W result
      // for both signed and unsigned forms.
      a_ext = is_signed ? $signed({{WIDTH{a[WIDTH-1]}}, a}) : $signed({{WIDTH{1'b0}}, a});
      b_ext = is_signed ? $signed({{WIDTH{b[WIDTH-1]}}, b}) : $signed({{WIDTH{1'b0}}, b});
      prod  = a_ext * b_ext;

      // One unsigned divider serves both forms; signed divide works on
      // magnitudes and fixes the signs afterwards (truncation toward zero).
      a_neg    = is_signed && a[WIDTH-1];
      b_neg    = is_signed && b[WIDTH-1];
      dvd      = a_neg ? (~a + WIDTH'(1)) : a;
      dvs      = b_neg ? (~b + WIDTH'(1)) : b;
      div_zero = (b == '0);
      dvs_safe = div_zero ? WIDTH'(1) : dvs;
      quo      = dvd / dvs_safe;
      rem      = dvd % dvs_safe;
      quo_fix  = (a_neg ^ b_neg) ? (~quo + WIDTH'(1)) : quo;
      rem_fix  = a_neg ? (~rem + WIDTH'(1)) : rem;
      div_ovf  = (op == MD_DIV) && (a == MIN_VAL) && (b == '1);

      hi_next = '0;
      lo_next = '0;
      case (op)
         MD_MULT, MD_MULTU: begin
            hi_next = prod[2*WIDTH-1:WIDTH];
            lo_next = prod[WIDTH-1:0];
         end
         MD_DIV, MD_DIVU: begin
            if (div_zero) begin
               hi_next = a;
               lo_next = '1;
            end else if (div_ovf) begin
               hi_next = '0;
               lo_next = a;
            end else begin
               hi_next = rem_fix;
               lo_next = quo_fix;
            end
         end
         default: begin
            hi_next = '0;
            lo_next = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a start/busy
// handshake; the result lands on HI/LO exactly L cycles after acceptance.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo
);

   localparam int               CNT_W    = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   md_state_t         state;
   md_state_t         state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   md_op_t            op_in;
   md_op_t            op_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  hi_res;
   logic [WIDTH-1:0]  lo_res;
   logic              accept_md;
   logic              write_res;
   logic              write_hi;
   logic              write_lo;

   assign op_in = md_op_t'(op);
   assign busy  = (state == RUN);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Requests are only looked at in IDLE, so anything arriving while busy
   // (including MTHI/MTLO) is dropped rather than queued.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept_md  = 1'b0;
      write_res  = 1'b0;
      write_hi   = 1'b0;
      write_lo   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (op_in)
                  MD_MULT, MD_MULTU: begin
                     accept_md  = 1'b1;
                     cnt_next   = MUL_LOAD;
                     state_next = RUN;
                  end
                  MD_DIV, MD_DIVU: begin
                     accept_md  = 1'b1;
                     cnt_next   = DIV_LOAD;
                     state_next = RUN;
                  end
                  MD_MTHI: write_hi = 1'b1;
                  MD_MTLO: write_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt == '0) begin
               write_res  = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept_md) begin
         op_q <= op_in;
         a_q  <= A;
         b_q  <= B;
      end
   end

   md_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .op      (op_q),
      .a       (a_q),
      .b       (b_q),
      .hi_next (hi_res),
      .lo_next (lo_res)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         done <= write_res;
         if (write_res) begin
            hi <= hi_res;
            lo <= lo_res;
         end else begin
            if (write_hi) hi <= A;
            if (write_lo) lo <= A;
         end
      end
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers.
- Successor to the combinational ALU: adds multi-cycle operations, a start/busy handshake and architectural HI/LO state.
- Sits in the EX stage beside the ALU. The pipeline stalls any md-class instruction while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, latency of MULT/MULTU in cycles; must be >=1.
- DIV_CYCLES, 10, latency of DIV/DIVU in cycles; must be >=1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled at clk rising edge.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- A  in  WIDTH  operand A; also the MTHI/MTLO source.
- B  in  WIDTH  operand B.
- busy  out  1  high while a multiply/divide is in flight.
- done  out  1  one-cycle pulse on the edge that HI/LO take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - busy=0, done=0, hi=0, lo=0, counter=0.
  - An in-flight operation is discarded and no result is written.
- Accept rule: start=1 and busy=0 at edge k.
  - A, B and op are latched internally; later input changes are ignored.
- Idle state, mul/div op accepted at edge k:
  - Go to RUN; busy=1 after edge k.
  - Counter loads L-1, where L = MUL_CYCLES or DIV_CYCLES.
- RUN state:
  - Counter decrements each edge.
  - On the edge where the counter is 0 (edge k+L): write hi/lo, busy=0, done=1 for one cycle, return to IDLE.
  - busy is high for exactly L cycles.
  - hi/lo keep their old values until edge k+L.
- MTHI/MTLO:
  - Accepted only when busy=0. At edge k, hi<=A (MTHI) or lo<=A (MTLO).
  - busy stays 0 and done stays 0.
- start while busy=1: ignored entirely, including MTHI/MTLO. No queueing.
- op 6/7 with start=1: no state change.
- Back-to-back: a new start is accepted in the same cycle that done=1 (busy is already 0).
- MULT: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper half, lo = lower half.
- MULTU: same as MULT with unsigned operands.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (DIV or DIVU with B=0): lo = all ones, hi = A.
- Signed overflow (DIV with A = most-negative value and B = -1): lo = A, hi = 0.
- Results are computed from the latched operands; arithmetic may be combinational, registered only at completion.
- Internal state machine: IDLE, RUN. Encoding is implementation choice.

Decomposition:
- Shared package md_pkg:
  - op code constants MD_MULT..MD_MTLO;
  - state encoding IDLE/RUN;
  - counter width as ceil-log2 of max(MUL_CYCLES, DIV_CYCLES)+1.
- One natural sub-module, md_calc:
  - purely combinational;
  - takes latched op/A/B and produces {hi_next, lo_next};
  - implements the divide-by-zero and overflow rules.
- md_unit holds the state machine, counter, latches and HI/LO registers.

Test Plan:
- Signed multiply: reset, then MULT A=32'h80000000, B=2 at edge 0.
  - busy=1 for exactly 5 cycles; done pulses at edge 5.
  - hi=32'hFFFFFFFF, lo=32'h00000000.
- Unsigned multiply: MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF.
  - hi=32'hFFFFFFFE, lo=32'h00000001 after 5 cycles.
- Signed divide and signed overflow:
  - DIV A=-7 (32'hFFFFFFF9), B=2: lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, busy=1 for 10 cycles.
  - DIV A=32'h80000000, B=-1: lo=32'h80000000, hi=0.
- Divide by zero and MTHI:
  - DIVU A=123, B=0: lo=32'hFFFFFFFF, hi=123.
  - Then MTHI A=5 with busy=0: hi=5 on the next edge, done stays 0.
- Start while busy:
  - Issue MULT 3*4; at cycle 2 pulse start with MTLO A=9.
  - MTLO is ignored; final lo=12, hi=0.
  - A new DIVU 12/5 issued in the done cycle is accepted: lo=2, hi=2 ten cycles later.
- Reset mid-operation:
  - Start DIV 100/3; assert reset_n=0 at cycle 4, asynchronously (between edges).
  - busy, done, hi and lo go to 0 immediately.
  - After release, no done pulse and hi=lo=0.
